// File: rtl/pattern_builder_if.sv
// Load-request channel of the pattern builder: one (shape, slot) request per
// cycle under a valid/ready handshake.
interface pattern_builder_if #(
   parameter int SHAPE_W = 3,
   parameter int SLOT_W  = 2
);
   logic               load_valid;
   logic               load_ready;
   logic [SHAPE_W-1:0] load_shape;
   logic [SLOT_W-1:0]  load_slot;

   modport master (
      output load_valid,
      output load_shape,
      output load_slot,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_shape,
      input  load_slot,
      output load_ready
   );
endinterface

// File: rtl/pattern_builder.sv
// Assembles a NUM_SLOTS x SHAPE_W master pattern from (shape, slot) loads in a
// start-delimited session, tracking duplicate and out-of-range requests.
module pattern_builder #(
   parameter int NUM_SLOTS = 4,
   parameter int SHAPE_W   = 3,
   parameter int OVERWRITE = 0,
   parameter int SLOT_W    = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   pattern_builder_if.slave             load,
   output logic [NUM_SLOTS*SHAPE_W-1:0] pattern,
   output logic [NUM_SLOTS-1:0]         filled,
   output logic                         busy,
   output logic                         done,
   output logic [3:0]                   dup_count,
   output logic                         range_err
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUILD = 2'd1, DONE = 2'd2} state_t;

   state_t                         state_r, state_s;
   logic [1:0]                     rst_sync_r;
   logic                           rst_int_s;
   logic [NUM_SLOTS*SHAPE_W-1:0]   pattern_r, pattern_s, pattern_wr_s;
   logic [NUM_SLOTS-1:0]           filled_r, filled_s, slot_hit_s;
   logic [3:0]                     dup_r, dup_s, dup_inc_s;
   logic                           range_r, range_s;
   logic                           busy_r, done_r;
   logic                           load_ready_s, accept_s, in_range_s, hit_filled_s;

   // Reset synchronizer: assertion is immediate, release is aligned to clock.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end

   assign rst_int_s    = rst_sync_r[1];
   assign load_ready_s = (state_r == BUILD) && !start;
   assign accept_s     = load.load_valid && load_ready_s;
   assign dup_inc_s    = (dup_r == 4'd15) ? 4'd15 : (dup_r + 4'd1);

   // Slot decode and the pattern image with the requested slot replaced.
   always_comb begin
      slot_hit_s   = {NUM_SLOTS{1'b0}};
      pattern_wr_s = pattern_r;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         slot_hit_s[k] = (load.load_slot == SLOT_W'(k));
         if (slot_hit_s[k]) begin
            pattern_wr_s[k*SHAPE_W +: SHAPE_W] = load.load_shape;
         end else begin
            pattern_wr_s[k*SHAPE_W +: SHAPE_W] = pattern_r[k*SHAPE_W +: SHAPE_W];
         end
      end
      in_range_s   = |slot_hit_s;
      hit_filled_s = |(slot_hit_s & filled_r);
   end

   // Next-state and datapath update; start overrides every state.
   always_comb begin
      state_s   = state_r;
      pattern_s = pattern_r;
      filled_s  = filled_r;
      dup_s     = dup_r;
      range_s   = range_r;
      if (start) begin
         state_s   = BUILD;
         pattern_s = {(NUM_SLOTS*SHAPE_W){1'b0}};
         filled_s  = {NUM_SLOTS{1'b0}};
         dup_s     = 4'd0;
         range_s   = 1'b0;
      end else begin
         case (state_r)
            IDLE: state_s = IDLE;
            BUILD: begin
               if (accept_s && in_range_s) begin
                  filled_s = filled_r | slot_hit_s;
                  if (!hit_filled_s || (OVERWRITE != 0)) begin
                     pattern_s = pattern_wr_s;
                  end else begin
                     pattern_s = pattern_r;
                  end
                  if (hit_filled_s) begin
                     dup_s = dup_inc_s;
                  end else begin
                     dup_s = dup_r;
                  end
               end else if (accept_s) begin
                  range_s = 1'b1;
               end else begin
                  range_s = range_r;
               end
               if (&filled_s) begin
                  state_s = DONE;
               end else begin
                  state_s = BUILD;
               end
            end
            DONE:    state_s = DONE;
            default: state_s = IDLE;
         endcase
      end
   end

   // State, datapath and status registers.
   always_ff @(posedge clock or negedge rst_int_s) begin
      if (!rst_int_s) begin
         state_r   <= IDLE;
         pattern_r <= {(NUM_SLOTS*SHAPE_W){1'b0}};
         filled_r  <= {NUM_SLOTS{1'b0}};
         dup_r     <= 4'd0;
         range_r   <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         pattern_r <= pattern_s;
         filled_r  <= filled_s;
         dup_r     <= dup_s;
         range_r   <= range_s;
         busy_r    <= (state_s == BUILD);
         done_r    <= (state_s == DONE);
      end
   end

   assign load.load_ready = load_ready_s;
   assign pattern         = pattern_r;
   assign filled          = filled_r;
   assign busy            = busy_r;
   assign done            = done_r;
   assign dup_count       = dup_r;
   assign range_err       = range_r;

endmodule

// File: tb/tb_pattern_builder.sv
// Directed bench: first-wins (a), last-wins (b) and 3-slot/4-bit (c) builders.
module tb_pattern_builder;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic start_ab = 1'b0;
   logic start_c = 1'b0;
   int   total = 0;
   int   passed = 0;

   logic [11:0] pattern_a, pattern_b, pattern_c;
   logic [3:0]  filled_a, filled_b;
   logic [2:0]  filled_c;
   logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
   logic [3:0]  dup_a, dup_b, dup_c;
   logic        range_a, range_b, range_c;

   pattern_builder_if #(.SHAPE_W(3), .SLOT_W(2)) if_a ();
   pattern_builder_if #(.SHAPE_W(3), .SLOT_W(2)) if_b ();
   pattern_builder_if #(.SHAPE_W(4), .SLOT_W(2)) if_c ();

   assign if_b.load_valid = if_a.load_valid;
   assign if_b.load_shape = if_a.load_shape;
   assign if_b.load_slot  = if_a.load_slot;

   always #5 clock = ~clock;

   pattern_builder #(.NUM_SLOTS(4), .SHAPE_W(3), .OVERWRITE(0)) dut_a (
      .clock(clock), .reset(reset), .start(start_ab), .load(if_a),
      .pattern(pattern_a), .filled(filled_a), .busy(busy_a), .done(done_a),
      .dup_count(dup_a), .range_err(range_a));

   pattern_builder #(.NUM_SLOTS(4), .SHAPE_W(3), .OVERWRITE(1)) dut_b (
      .clock(clock), .reset(reset), .start(start_ab), .load(if_b),
      .pattern(pattern_b), .filled(filled_b), .busy(busy_b), .done(done_b),
      .dup_count(dup_b), .range_err(range_b));

   pattern_builder #(.NUM_SLOTS(3), .SHAPE_W(4), .OVERWRITE(0)) dut_c (
      .clock(clock), .reset(reset), .start(start_c), .load(if_c),
      .pattern(pattern_c), .filled(filled_c), .busy(busy_c), .done(done_c),
      .dup_count(dup_c), .range_err(range_c));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load_ab(input logic [1:0] slot, input logic [2:0] shape);
      if_a.load_slot  = slot;
      if_a.load_shape = shape;
      if_a.load_valid = 1'b1;
      tick();
      if_a.load_valid = 1'b0;
   endtask

   task automatic load_c(input logic [1:0] slot, input logic [3:0] shape);
      if_c.load_slot  = slot;
      if_c.load_shape = shape;
      if_c.load_valid = 1'b1;
      tick();
      if_c.load_valid = 1'b0;
   endtask

   task automatic pulse_ab();
      start_ab = 1'b1;
      tick();
      start_ab = 1'b0;
   endtask

   initial begin
      if_a.load_valid = 1'b0; if_a.load_slot = 2'd0; if_a.load_shape = 3'd0;
      if_c.load_valid = 1'b0; if_c.load_slot = 2'd0; if_c.load_shape = 4'd0;
      #1;
      check("rst_pattern", {52'd0, pattern_a}, 64'd0);
      check("rst_filled", {60'd0, filled_a}, 64'd0);
      check("rst_busy_done", {62'd0, busy_a, done_a}, 64'd0);
      check("rst_dup_range", {59'd0, dup_a, range_a}, 64'd0);
      check("rst_ready", {63'd0, if_a.load_ready}, 64'd0);
      #11 reset = 1'b1;
      repeat (3) tick();

      // loads while idle are ignored
      if_a.load_slot = 2'd0; if_a.load_shape = 3'b111; if_a.load_valid = 1'b1;
      tick(); tick();
      check("idle_ready", {63'd0, if_a.load_ready}, 64'd0);
      check("idle_filled", {60'd0, filled_a}, 64'd0);
      check("idle_pattern", {52'd0, pattern_a}, 64'd0);
      start_ab = 1'b1;
      #1;
      check("ready_during_start", {63'd0, if_a.load_ready}, 64'd0);
      @(posedge clock); #1;
      start_ab = 1'b0;
      #1;
      check("ready_after_start", {62'd0, busy_a, if_a.load_ready}, 64'd3);
      check("no_accept_on_start", {60'd0, filled_a}, 64'd0);
      tick();
      if_a.load_valid = 1'b0;
      check("first_load_filled", {60'd0, filled_a}, 64'h1);
      check("first_load_pattern", {52'd0, pattern_a}, 64'h7);

      // main sequence on both overwrite modes
      pulse_ab();
      check("restart_clear", {48'd0, pattern_a, filled_a}, 64'd0);
      load_ab(2'd3, 3'b001);
      check("a_slot3", {52'd0, pattern_a}, 64'h200);
      load_ab(2'd3, 3'b110);
      check("a_dup1", {52'd0, pattern_a, dup_a}, {52'h200, 4'd1});
      check("b_dup1", {52'd0, pattern_b, dup_b}, {52'hC00, 4'd1});
      load_ab(2'd1, 3'b101);
      load_ab(2'd1, 3'b110);
      load_ab(2'd0, 3'b110);
      load_ab(2'd0, 3'b001);
      check("a_not_done", {62'd0, busy_a, done_a}, 64'd2);
      check("a_filled_partial", {60'd0, filled_a}, 64'hB);
      load_ab(2'd2, 3'b010);
      check("a_pattern", {52'd0, pattern_a}, 64'h2AE);
      check("b_pattern", {52'd0, pattern_b}, 64'hCB1);
      check("a_dup3", {60'd0, dup_a}, 64'd3);
      check("b_dup3", {60'd0, dup_b}, 64'd3);
      check("a_done", {58'd0, busy_a, done_a, filled_a}, {58'd0, 2'b01, 4'hF});
      check("b_done", {58'd0, busy_b, done_b, filled_b}, {58'd0, 2'b01, 4'hF});

      // loads in DONE are refused
      if_a.load_slot = 2'd0; if_a.load_shape = 3'b111; if_a.load_valid = 1'b1;
      #1;
      check("done_ready", {63'd0, if_a.load_ready}, 64'd0);
      tick();
      if_a.load_valid = 1'b0;
      check("done_frozen", {48'd0, pattern_a, dup_a}, {48'd0, 12'h2AE, 4'd3});
      check("done_held", {63'd0, done_a}, 64'd1);
      pulse_ab();
      check("restart_pattern", {52'd0, pattern_a}, 64'd0);
      check("restart_status", {56'd0, filled_a, dup_a}, 64'd0);
      check("restart_busy", {62'd0, busy_a, done_a}, 64'd2);

      // duplicate counter saturation
      for (int i = 0; i < 20; i++) load_ab(2'd0, 3'b101);
      check("a_dup_sat", {60'd0, dup_a}, 64'd15);
      check("b_dup_sat", {60'd0, dup_b}, 64'd15);
      check("sat_filled", {60'd0, filled_a}, 64'h1);

      // asynchronous reset mid-session
      load_ab(2'd1, 3'b011);
      check("pre_reset_filled", {60'd0, filled_a}, 64'h3);
      #2 reset = 1'b0;
      #1;
      check("async_pattern", {40'd0, pattern_a, pattern_b}, 64'd0);
      check("async_filled", {60'd0, filled_a}, 64'd0);
      check("async_dup", {56'd0, dup_a, dup_b}, 64'd0);
      check("async_flags", {61'd0, busy_a, done_a, if_a.load_ready}, 64'd0);
      #3 reset = 1'b1;
      repeat (3) tick();
      check("post_reset_idle", {62'd0, busy_a, done_a}, 64'd0);

      // 3-slot, 4-bit variant with out-of-range request
      check("c_ready_idle", {63'd0, if_c.load_ready}, 64'd0);
      start_c = 1'b1;
      tick();
      start_c = 1'b0;
      check("c_busy", {63'd0, busy_c}, 64'd1);
      load_c(2'd3, 4'b1111);
      check("c_range", {59'd0, range_c, filled_c, done_c}, {59'd0, 1'b1, 3'b000, 1'b0});
      check("c_range_nodup", {60'd0, dup_c}, 64'd0);
      load_c(2'd0, 4'b1010);
      load_c(2'd1, 4'b0101);
      check("c_not_done", {63'd0, done_c}, 64'd0);
      load_c(2'd2, 4'b1111);
      check("c_pattern", {52'd0, pattern_c}, 64'hF5A);
      check("c_done", {58'd0, busy_c, done_c, range_c, filled_c}, {58'd0, 3'b011, 3'b111});
      start_c = 1'b1;
      tick();
      start_c = 1'b0;
      check("c_restart", {48'd0, pattern_c, range_c, filled_c}, 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
